// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the datapath and pipeline_hazard_ctrl: hit/hazard
// status into the controller, latch enables/flushes and halt back out.
interface pipeline_hazard_ctrl_if #(
  parameter int RADDR_W = 5
);
  logic               ihit;
  logic               dhit;
  logic [RADDR_W-1:0] id_rs;
  logic [RADDR_W-1:0] id_rt;
  logic               ex_dREN;
  logic [RADDR_W-1:0] ex_wsel;
  logic               mem_dREN;
  logic               mem_dWEN;
  logic               mem_redirect;
  logic               wb_halt;

  logic               pc_en;
  logic               fd_en;
  logic               fd_flush;
  logic               de_en;
  logic               de_flush;
  logic               em_en;
  logic               em_flush;
  logic               mw_en;
  logic               mw_flush;
  logic               halt;

  modport master (
    output ihit, dhit, id_rs, id_rt, ex_dREN, ex_wsel,
           mem_dREN, mem_dWEN, mem_redirect, wb_halt,
    input  pc_en, fd_en, fd_flush, de_en, de_flush,
           em_en, em_flush, mw_en, mw_flush, halt
  );

  modport slave (
    input  ihit, dhit, id_rs, id_rt, ex_dREN, ex_wsel,
           mem_dREN, mem_dWEN, mem_redirect, wb_halt,
    output pc_en, fd_en, fd_flush, de_en, de_flush,
           em_en, em_flush, mw_en, mw_flush, halt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch sequencer: per-cycle en/flush/pc_en from cache hits, load-use,
// redirects and halt. Optional statistics counters under `HAZARD_STATS_EN.
module pipeline_hazard_ctrl #(
  parameter int RADDR_W = 5
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                  CLK,
  input  logic                  nRST,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0]    stall_cnt
  , output logic [CNT_W-1:0]    flush_cnt
  , output logic [CNT_W-1:0]    dwait_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    R_OFF    = 3'd0,
    R_HALTED = 3'd1,
    R_WBHALT = 3'd2,
    R_DBUSY  = 3'd3,
    R_REDIR  = 3'd4,
    R_LDUSE  = 3'd5,
    R_IMISS  = 3'd6,
    R_FLOW   = 3'd7
  } rule_e;

  // Bit order: pc_en fd_en fd_flush de_en de_flush em_en em_flush mw_en mw_flush halt
  localparam logic [9:0] CTRL_OFF    = 10'b00_0000_0000;
  localparam logic [9:0] CTRL_HALTED = 10'b00_0000_0001;
  localparam logic [9:0] CTRL_WBHALT = 10'b00_0000_0100;
  localparam logic [9:0] CTRL_REDIR  = 10'b10_1010_1100;
  localparam logic [9:0] CTRL_LDUSE  = 10'b00_0011_0100;
  localparam logic [9:0] CTRL_IMISS  = 10'b00_1101_0100;
  localparam logic [9:0] CTRL_FLOW   = 10'b11_0101_0100;

  state_e     state_q;
  state_e     state_d;
  rule_e      rule_s;
  logic [9:0] ctrl_s;
  logic       dmem_busy_s;
  logic       load_use_s;

  assign dmem_busy_s = (hz.mem_dREN | hz.mem_dWEN) & ~hz.dhit;
  // Register $zero is hard-wired, so a load targeting it never creates a hazard.
  assign load_use_s  = hz.ex_dREN & (hz.ex_wsel != {RADDR_W{1'b0}}) &
                       ((hz.ex_wsel == hz.id_rs) | (hz.ex_wsel == hz.id_rt));

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: HALT is absorbing until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: state_d = ST_HALT;
      ST_RUN, ST_DWAIT: begin
        if (hz.wb_halt) begin
          state_d = ST_HALT;
        end else if (dmem_busy_s) begin
          state_d = ST_DWAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output logic stage 1: pick the highest-priority active rule.
  always_comb begin
    rule_s = R_OFF;
    if (!nRST) begin
      rule_s = R_OFF;
    end else if (state_q == ST_HALT) begin
      rule_s = R_HALTED;
    end else if (hz.wb_halt) begin
      rule_s = R_WBHALT;
    end else if (dmem_busy_s) begin
      rule_s = R_DBUSY;
    end else if (hz.mem_redirect) begin
      rule_s = R_REDIR;
    end else if (load_use_s) begin
      rule_s = R_LDUSE;
    end else if (!hz.ihit) begin
      rule_s = R_IMISS;
    end else begin
      rule_s = R_FLOW;
    end
  end

  // Output logic stage 2: map the active rule onto the latch control word.
  always_comb begin
    ctrl_s = CTRL_OFF;
    case (rule_s)
      R_OFF:    ctrl_s = CTRL_OFF;
      R_HALTED: ctrl_s = CTRL_HALTED;
      R_WBHALT: ctrl_s = CTRL_WBHALT;
      R_DBUSY:  ctrl_s = CTRL_OFF;
      R_REDIR:  ctrl_s = CTRL_REDIR;
      R_LDUSE:  ctrl_s = CTRL_LDUSE;
      R_IMISS:  ctrl_s = CTRL_IMISS;
      R_FLOW:   ctrl_s = CTRL_FLOW;
      default:  ctrl_s = CTRL_OFF;
    endcase
  end

  assign {hz.pc_en, hz.fd_en, hz.fd_flush, hz.de_en, hz.de_flush,
          hz.em_en, hz.em_flush, hz.mw_en, hz.mw_flush, hz.halt} = ctrl_s;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] dwait_q, dwait_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = v;
    end
  endfunction

  // Counter next-state: rule codes are never active in HALT, so counts freeze there.
  always_comb begin
    stall_d = sat_inc(stall_q, rule_s == R_LDUSE);
    flush_d = sat_inc(flush_q, rule_s == R_REDIR);
    dwait_d = sat_inc(dwait_q, rule_s == R_DBUSY);
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= {CNT_W{1'b0}};
      flush_q <= {CNT_W{1'b0}};
      dwait_q <= {CNT_W{1'b0}};
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      dwait_q <= dwait_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign dwait_cnt = dwait_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench for pipeline_hazard_ctrl against a per-output
// boolean reference model; honours HAZARD_STATS_EN for the counter outputs.
module tb_pipeline_hazard_ctrl;
  localparam int RADDR_W = 5;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl_if #(.RADDR_W(RADDR_W)) hz ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt, dwait_cnt;
  pipeline_hazard_ctrl #(.RADDR_W(RADDR_W), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .hz(hz.slave),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dwait_cnt(dwait_cnt)
  );
`else
  pipeline_hazard_ctrl #(.RADDR_W(RADDR_W)) dut (
    .CLK(CLK), .nRST(nRST), .hz(hz.slave)
  );
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit m_halted = 1'b0;
  int m_stall = 0;
  int m_flush = 0;
  int m_dwait = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] dut_ctrl();
    return {hz.pc_en, hz.fd_en, hz.fd_flush, hz.de_en, hz.de_flush,
            hz.em_en, hz.em_flush, hz.mw_en, hz.mw_flush, hz.halt};
  endfunction

  task automatic drive(input bit ihit, input bit dhit, input int rs, input int rt,
                       input bit exl, input int wsel, input bit mr, input bit mw,
                       input bit redir, input bit wb);
    hz.ihit = ihit;  hz.dhit = dhit;
    hz.id_rs = RADDR_W'(rs); hz.id_rt = RADDR_W'(rt);
    hz.ex_dREN = exl; hz.ex_wsel = RADDR_W'(wsel);
    hz.mem_dREN = mr; hz.mem_dWEN = mw;
    hz.mem_redirect = redir; hz.wb_halt = wb;
  endtask

  // Called just after a falling edge with inputs applied; checks, then advances one cycle.
  task automatic run_cycle(input string tag);
    bit a, go, lu, busy;
    logic [9:0] exp;
    if (!nRST) begin
      m_halted = 1'b0; m_stall = 0; m_flush = 0; m_dwait = 0;
    end
    #1;
    busy = (hz.mem_dREN || hz.mem_dWEN) && !hz.dhit;
    lu   = hz.ex_dREN && (hz.ex_wsel != 0) &&
           (hz.ex_wsel == hz.id_rs || hz.ex_wsel == hz.id_rt);
    a    = nRST && !m_halted;
    go   = a && !hz.wb_halt && !busy;
    exp[9] = go && (hz.mem_redirect || (!lu && hz.ihit));
    exp[8] = go && !hz.mem_redirect && !lu && hz.ihit;
    exp[7] = go && (hz.mem_redirect || (!lu && !hz.ihit));
    exp[6] = go && !hz.mem_redirect && !lu;
    exp[5] = go && (hz.mem_redirect || lu);
    exp[4] = go && !hz.mem_redirect;
    exp[3] = go && hz.mem_redirect;
    exp[2] = a && (hz.wb_halt || go);
    exp[1] = 1'b0;
    exp[0] = nRST && m_halted;
    check_val(tag, {22'd0, dut_ctrl()}, {22'd0, exp});
`ifdef HAZARD_STATS_EN
    check_val({tag, "_stall"}, stall_cnt, m_stall);
    check_val({tag, "_flush"}, flush_cnt, m_flush);
    check_val({tag, "_dwait"}, dwait_cnt, m_dwait);
`endif
    @(posedge CLK);
    if (a) begin
      if (hz.wb_halt) m_halted = 1'b1;
      else if (busy) m_dwait++;
      else if (hz.mem_redirect) m_flush++;
      else if (lu) m_stall++;
    end
    @(negedge CLK);
  endtask

  task automatic rand_inputs();
    drive($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 2) == 0, $urandom_range(0, 3),
          $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 60) == 0);
  endtask

  initial begin
    int halt_run;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    @(negedge CLK);
    run_cycle("reset0");
    check_val("reset_all_zero", {22'd0, dut_ctrl()}, 32'd0);
    run_cycle("reset1");
    nRST = 1'b1;
    run_cycle("run_after_reset");

    drive(1, 0, 0, 8, 1, 8, 0, 0, 0, 0);
    #1 check_val("loaduse_const", {22'd0, dut_ctrl()}, {22'd0, 10'b0000110100});
    run_cycle("loaduse");
    drive(1, 0, 0, 8, 0, 8, 0, 0, 0, 0);
    run_cycle("loaduse_after");
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    run_cycle("loaduse_zero");

    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      run_cycle("dmiss_wait");
    end
    drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    #1 check_val("dmiss_release", {22'd0, dut_ctrl()}, {22'd0, 10'b1101010100});
    run_cycle("dmiss_hit");
`ifdef HAZARD_STATS_EN
    check_val("dwait_is_3", dwait_cnt, 32'd3);
`endif

    drive(1, 0, 3, 3, 1, 3, 0, 0, 1, 0);
    #1 check_val("redir_lu_const", {22'd0, dut_ctrl()}, {22'd0, 10'b1010101100});
    run_cycle("redir_loaduse");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("imiss");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    run_cycle("redir_imiss");

    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    #1 check_val("halt_mw_only", {22'd0, dut_ctrl()}, {22'd0, 10'b0000000100});
    run_cycle("halt_entry");
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      run_cycle("halted");
    end
    nRST = 1'b0;
    run_cycle("halt_reset");
    nRST = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("halt_cleared");

    // Reset mid-DWAIT returns to RUN
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    run_cycle("dwait_pre_reset");
    nRST = 1'b0;
    run_cycle("dwait_reset");
    nRST = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("dwait_reset_run");

    halt_run = 0;
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      if (m_halted) halt_run++;
      if (halt_run > 12) begin
        nRST = 1'b0;
        halt_run = 0;
      end else begin
        nRST = ($urandom_range(0, 400) != 0);
      end
      run_cycle("random");
      nRST = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
